// File: rtl/scene_renderer.sv
// scene_renderer: Flappy Bird pixel source. The colour is combinational from row/col, and frame_tick is registered one cycle after vblank starts.
// upd_ready stays low while a shadow update waits for vblank. Defining SCENE_GAMEOVER_TINT_EN adds the game-over tint.
module scene_renderer #(
    parameter int unsigned BIRD_X   = 160,
    parameter int unsigned BIRD_SZ  = 16,
    parameter int unsigned PIPE_W   = 52,
    parameter int unsigned GAP_H    = 120,
    parameter int unsigned GROUND_Y = 440,
    parameter int unsigned ANIM_DIV = 8
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] pixel,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [8:0]  bird_y,
    input  logic [9:0]  pipe_x,
    input  logic [8:0]  gap_y,
    input  logic        game_over,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);
    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [11:0] COL_BIRD    = 12'h0FF;
    localparam logic [11:0] COL_BIRD_UP = 12'h0AF;
    localparam logic [11:0] COL_GROUND  = 12'h06A;
    localparam logic [11:0] COL_PIPE    = 12'h0C2;
    localparam logic [11:0] COL_SKY     = 12'hFC8;

    logic             rdn_q;
    logic             frame_tick_q, frame_tick_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       phase_q, phase_d;
    logic             pending_q, pending_d;
    logic [8:0]       sh_bird_q, sh_bird_d;
    logic [9:0]       sh_pipe_q, sh_pipe_d;
    logic [8:0]       sh_gap_q, sh_gap_d;
    logic [8:0]       act_bird_q, act_bird_d;
    logic [9:0]       act_pipe_q, act_pipe_d;
    logic [8:0]       act_gap_q, act_gap_d;

    logic vblank_start;
    logic upd_fire;

    // Rising edge of rdn on the last visible line marks the start of vertical blank.
    assign vblank_start = ~rdn_q & rdn & (row_addr == 9'd479);
    assign upd_ready    = ~pending_q;
    assign upd_fire     = upd_valid & ~pending_q;
    assign frame_tick   = frame_tick_q;
    assign frame_cnt    = frame_cnt_q;

    always_comb begin
        frame_tick_d = vblank_start;
        frame_cnt_d  = frame_cnt_q;
        div_d        = div_q;
        phase_d      = phase_q;
        pending_d    = pending_q;
        sh_bird_d    = sh_bird_q;
        sh_pipe_d    = sh_pipe_q;
        sh_gap_d     = sh_gap_q;
        act_bird_d   = act_bird_q;
        act_pipe_d   = act_pipe_q;
        act_gap_d    = act_gap_q;
        if (vblank_start) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            if (pending_q) begin
                act_bird_d = sh_bird_q;
                act_pipe_d = sh_pipe_q;
                act_gap_d  = sh_gap_q;
                pending_d  = 1'b0;
            end
        end
        // Acceptance needs pending==0, so it never collides with the shadow-to-active copy.
        if (upd_fire) begin
            sh_bird_d = bird_y;
            sh_pipe_d = pipe_x;
            sh_gap_d  = gap_y;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            rdn_q        <= 1'b1;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            div_q        <= '0;
            phase_q      <= 2'd0;
            pending_q    <= 1'b0;
            sh_bird_q    <= 9'd232;
            sh_pipe_q    <= 10'd640;
            sh_gap_q     <= 9'd180;
            act_bird_q   <= 9'd232;
            act_pipe_q   <= 10'd640;
            act_gap_q    <= 9'd180;
        end else begin
            rdn_q        <= rdn;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            pending_q    <= pending_d;
            sh_bird_q    <= sh_bird_d;
            sh_pipe_q    <= sh_pipe_d;
            sh_gap_q     <= sh_gap_d;
            act_bird_q   <= act_bird_d;
            act_pipe_q   <= act_pipe_d;
            act_gap_q    <= act_gap_d;
        end
    end

    logic [9:0]  row10, bird_dr, bird_dc, pipe_dc, gap_top, gap_end;
    logic        hit_bird, hit_pipe, in_gap, hit_ground;
    logic [11:0] scene_col;

    // Unsigned 10-bit differences let the pipe wrap across column 1023 -> 0.
    always_comb begin
        row10      = {1'b0, row_addr};
        bird_dr    = row10 - {1'b0, act_bird_q};
        bird_dc    = col_addr - 10'(BIRD_X);
        pipe_dc    = col_addr - act_pipe_q;
        gap_top    = {1'b0, act_gap_q};
        gap_end    = gap_top + 10'(GAP_H);
        hit_bird   = (bird_dr < 10'(BIRD_SZ)) && (bird_dc < 10'(BIRD_SZ));
        hit_pipe   = pipe_dc < 10'(PIPE_W);
        in_gap     = (row10 >= gap_top) && (row10 < gap_end);
        hit_ground = row10 >= 10'(GROUND_Y);
        if (hit_bird)
            scene_col = phase_q[1] ? COL_BIRD_UP : COL_BIRD;
        else if (hit_ground)
            scene_col = COL_GROUND;
        else if (hit_pipe && !in_gap)
            scene_col = COL_PIPE;
        else
            scene_col = COL_SKY;
    end

`ifdef SCENE_GAMEOVER_TINT_EN
    always_comb begin
        if (rdn)
            pixel = 12'h000;
        else if (game_over)
            pixel = {1'b0, scene_col[11:9], 1'b0, scene_col[7:5], 4'hF};
        else
            pixel = scene_col;
    end
`else
    logic unused_game_over;
    assign unused_game_over = game_over;
    assign pixel = rdn ? 12'h000 : scene_col;
`endif

endmodule
